// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer.
// Holds up to DEPTH = 2**IDX_W in-flight instructions in program order. Results
// arrive from two writeback ports. One instruction retires per cycle from the head.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state and quiets commit outputs
//   disp_*              dispatch request/handshake; disp_tag is the allotted tail tag
//   alu_wb_*, lsb_wb_*  writeback ports (ALU/branch, load-store)
//   q1_*, q2_*          operand lookup with same-cycle writeback bypass
//   commit_*            retiring head entry (register file)
//   store_commit_*      store release handshake for a STORE at the head
//   bht_*               resolved branch outcome at retire
//   redirect_*          mispredict restart; also flushes the buffer at that edge
//   count               occupancy, 0..DEPTH
module rob_param #(
    parameter int IDX_W = 5,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             disp_valid,
    output logic             disp_ready,
    output logic [IDX_W-1:0] disp_tag,
    input  logic [1:0]       disp_type,
    input  logic [XLEN-1:0]  disp_pc,
    input  logic [4:0]       disp_rd,
    input  logic             disp_pred_taken,
    input  logic             alu_wb_valid,
    input  logic [IDX_W-1:0] alu_wb_tag,
    input  logic [XLEN-1:0]  alu_wb_value,
    input  logic             alu_wb_taken,
    input  logic [XLEN-1:0]  alu_wb_target,
    input  logic             lsb_wb_valid,
    input  logic [IDX_W-1:0] lsb_wb_tag,
    input  logic [XLEN-1:0]  lsb_wb_value,
    input  logic [IDX_W-1:0] q1_tag,
    input  logic [IDX_W-1:0] q2_tag,
    output logic             q1_ready,
    output logic [XLEN-1:0]  q1_value,
    output logic             q2_ready,
    output logic [XLEN-1:0]  q2_value,
    output logic             commit_valid,
    output logic [IDX_W-1:0] commit_tag,
    output logic [4:0]       commit_rd,
    output logic [XLEN-1:0]  commit_value,
    output logic             commit_wr,
    output logic             store_commit_valid,
    input  logic             store_commit_ready,
    output logic             bht_valid,
    output logic [XLEN-1:0]  bht_pc,
    output logic             bht_taken,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [IDX_W:0]   count
);

    localparam int DEPTH = 2**IDX_W;
    localparam logic [IDX_W:0] DEPTH_CNT = {1'b1, {IDX_W{1'b0}}};

    localparam logic [1:0] T_ALU    = 2'b00;
    localparam logic [1:0] T_BRANCH = 2'b01;
    localparam logic [1:0] T_JALR   = 2'b10;
    localparam logic [1:0] T_STORE  = 2'b11;

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [DEPTH-1:0] e_valid;
    logic [DEPTH-1:0] e_ready;
    logic [DEPTH-1:0] e_pred;
    logic [DEPTH-1:0] e_taken;
    logic [1:0]       e_type   [DEPTH];
    logic [4:0]       e_rd     [DEPTH];
    logic [XLEN-1:0]  e_pc     [DEPTH];
    logic [XLEN-1:0]  e_value  [DEPTH];
    logic [XLEN-1:0]  e_target [DEPTH];

    logic       head_ok;
    logic [1:0] h_type;
    logic       commit_fire;
    logic       mispredict;
    logic       flush;
    logic       disp_fire;

    assign disp_ready = rdy && (count != DEPTH_CNT);
    assign disp_fire  = disp_valid && disp_ready;
    assign disp_tag   = tail;

    assign h_type  = e_type[head];
    assign head_ok = rdy && (count != '0) && e_valid[head] && e_ready[head];

    // A ready store only leaves the head once the store buffer takes it.
    assign commit_fire = head_ok && ((h_type != T_STORE) || store_commit_ready);
    assign mispredict  = (h_type == T_JALR) ||
                         ((h_type == T_BRANCH) && (e_taken[head] != e_pred[head]));
    assign flush       = commit_fire && mispredict;

    assign commit_valid       = commit_fire;
    assign commit_tag         = commit_fire ? head : '0;
    assign commit_rd          = commit_fire ? e_rd[head] : '0;
    assign commit_value       = commit_fire ? e_value[head] : '0;
    assign commit_wr          = commit_fire && ((h_type == T_ALU) || (h_type == T_JALR)) &&
                                (e_rd[head] != 5'd0);
    assign store_commit_valid = head_ok && (h_type == T_STORE);
    assign bht_valid          = commit_fire && (h_type == T_BRANCH);
    assign bht_pc             = bht_valid ? e_pc[head] : '0;
    assign bht_taken          = bht_valid && e_taken[head];
    assign redirect_valid     = flush;
    assign redirect_pc        = !flush ? '0 :
                                ((h_type == T_JALR) || e_taken[head]) ? e_target[head] :
                                e_pc[head] + XLEN'(4);

    // Returns {ready, value}; a writeback this cycle wins over the stored entry.
    function automatic logic [XLEN:0] lookup(input logic [IDX_W-1:0] t);
        logic [XLEN:0] r;
        r = '0;
        if (e_valid[t]) begin
            if (alu_wb_valid && (alu_wb_tag == t))
                r = {1'b1, alu_wb_value};
            else if (lsb_wb_valid && (lsb_wb_tag == t))
                r = {1'b1, lsb_wb_value};
            else
                r = {e_ready[t], e_value[t]};
        end
        return r;
    endfunction

    assign {q1_ready, q1_value} = lookup(q1_tag);
    assign {q2_ready, q2_value} = lookup(q2_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            e_valid <= '0;
            e_ready <= '0;
        end else if (rdy) begin
            if (flush) begin
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                e_valid <= '0;
                e_ready <= '0;
            end else begin
                // Tail slot is never valid when a dispatch fires, so writebacks
                // cannot collide with the newly written entry.
                if (disp_fire) begin
                    e_valid[tail] <= 1'b1;
                    e_ready[tail] <= 1'b0;
                    tail          <= tail + IDX_W'(1);
                end
                if (alu_wb_valid && e_valid[alu_wb_tag])
                    e_ready[alu_wb_tag] <= 1'b1;
                if (lsb_wb_valid && e_valid[lsb_wb_tag])
                    e_ready[lsb_wb_tag] <= 1'b1;
                if (commit_fire) begin
                    e_valid[head] <= 1'b0;
                    e_ready[head] <= 1'b0;
                    head          <= head + IDX_W'(1);
                end
                count <= count + (IDX_W+1)'(disp_fire) - (IDX_W+1)'(commit_fire);
            end
        end
    end

    // Payload carries no reset; it is only meaningful while the entry is valid.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !flush) begin
            if (disp_fire) begin
                e_type[tail]  <= disp_type;
                e_pc[tail]    <= disp_pc;
                e_rd[tail]    <= disp_rd;
                e_pred[tail]  <= disp_pred_taken;
                e_taken[tail] <= 1'b0;
            end
            if (lsb_wb_valid && e_valid[lsb_wb_tag])
                e_value[lsb_wb_tag] <= lsb_wb_value;
            if (alu_wb_valid && e_valid[alu_wb_tag]) begin
                e_value[alu_wb_tag]  <= alu_wb_value;
                e_taken[alu_wb_tag]  <= alu_wb_taken;
                e_target[alu_wb_tag] <= alu_wb_target;
            end
        end
    end

endmodule
